// File: rtl/ram_rd_stream.sv
// ram_rd_stream: read-side streaming engine for a dual-port block RAM.
// Turns a (start_addr, len) command into a valid/ready stream. The RAM's
// one-cycle registered read is hidden behind a 2-entry buffer. The
// in-flight word is bypassed straight to the output, so the first beat
// appears two cycles after start and a full beat rate is kept under
// backpressure.
// Optional feature: define RAM_RD_STREAM_LAST_EN to add the out_last port.
module ram_rd_stream #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 9
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 start,
   input  logic [ADDRWIDTH-1:0] start_addr,
   input  logic [ADDRWIDTH:0]   len,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [ADDRWIDTH-1:0] ram_rd_addr,
   input  logic [DATAWIDTH-1:0] ram_rd_data,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef RAM_RD_STREAM_LAST_EN
   ,
   output logic                 out_last
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADDRWIDTH-1:0]   addr_q, addr_d;
   logic [ADDRWIDTH:0]     issue_cnt_q, issue_cnt_d;
   logic [ADDRWIDTH:0]     beat_cnt_q, beat_cnt_d;
   logic                   inflight_q, inflight_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [DATAWIDTH-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
   logic                   done_q, done_d;

   // Working signals: w0/w1 are the oldest and second-oldest pending words.
   // Each comes from the buffer or from the RAM read that lands this cycle.
   logic [DATAWIDTH-1:0]   w0, w1;
   logic [1:0]             total;
   logic                   pop, issue;

   // Pending-word view, stream outputs and issue permission.
   always_comb begin
      total     = cnt_q + {1'b0, inflight_q};
      w0        = (cnt_q != 2'd0) ? buf0_q : ram_rd_data;
      w1        = (cnt_q == 2'd2) ? buf1_q : ram_rd_data;
      out_valid = (total != 2'd0);
      out_data  = out_valid ? w0 : '0;
      pop       = out_valid & out_ready;
      issue     = (state_q == RUN) && !abort && (issue_cnt_q != '0) &&
                  ((total - {1'b0, pop}) < 2'd2);
   end

   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign ram_rd_addr = addr_q;

   // Next-state: FSM, address/count bookkeeping and buffer shifting.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      addr_d      = addr_q;
      issue_cnt_d = issue_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      inflight_d  = issue;
      done_d      = 1'b0;
      buf1_d      = buf1_q;
      if (pop) begin
         buf0_d = w1;
         cnt_d  = total - 2'd1;
      end else begin
         buf0_d = w0;
         buf1_d = w1;
         cnt_d  = total;
      end
      if (issue) begin
         addr_d      = addr_q + ADDRWIDTH'(1);
         issue_cnt_d = issue_cnt_q - (ADDRWIDTH+1)'(1);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d     = RUN;
                  addr_d      = start_addr;
                  issue_cnt_d = len;
                  beat_cnt_d  = len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d    = IDLE;
               cnt_d      = 2'd0;
               inflight_d = 1'b0;
            end else if (pop) begin
               beat_cnt_d = beat_cnt_q - (ADDRWIDTH+1)'(1);
               if (beat_cnt_q == (ADDRWIDTH+1)'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with asynchronous clear.
   always_ff @(posedge clk or negedge reset_l) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset_l) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         inflight_q  <= 1'b0;
         cnt_q       <= 2'd0;
         // NOTE: the two buffer words are plain flops, so they are reset too; a RAM macro would not be.
         buf0_q      <= '0;
         buf1_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         issue_cnt_q <= issue_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         inflight_q  <= inflight_d;
         cnt_q       <= cnt_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         done_q      <= done_d;
      end
   end

`ifdef RAM_RD_STREAM_LAST_EN
   logic last0_q, last0_d, last1_q, last1_d, inflight_last_q, inflight_last_d;
   logic w0_last, w1_last;

   // Last-beat flags travel alongside the data words through the buffer.
   always_comb begin
      w0_last         = (cnt_q != 2'd0) ? last0_q : inflight_last_q;
      w1_last         = (cnt_q == 2'd2) ? last1_q : inflight_last_q;
      out_last        = out_valid & w0_last;
      inflight_last_d = issue && (issue_cnt_q == (ADDRWIDTH+1)'(1));
      last1_d         = last1_q;
      if (pop) begin
         last0_d = w1_last;
      end else begin
         last0_d = w0_last;
         last1_d = w1_last;
      end
   end

   // Last-flag registers.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         last0_q         <= 1'b0;
         last1_q         <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         last0_q         <= last0_d;
         last1_q         <= last1_d;
         inflight_last_q <= inflight_last_d;
      end
   end
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// Testbench for ram_rd_stream. Includes a RAM model with a registered read.
// The expected stream for each command is computed straight from the RAM
// contents and the command itself: words mem[(start_addr+k) mod depth].
module tb_ram_rd_stream;
   localparam int DW    = 8;
   localparam int AW    = 9;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_l = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   len = '0;
   logic          abort = 1'b0;
   logic          busy, done, out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data, out_data;
`ifdef RAM_RD_STREAM_LAST_EN
   logic          out_last;
`endif

   logic [DW-1:0] mem [DEPTH];
   int            errors = 0;
   int            checks = 0;

   ram_rd_stream #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
      .clk(clk), .reset_l(reset_l), .start(start), .start_addr(start_addr),
      .len(len), .abort(abort), .busy(busy), .done(done),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef RAM_RD_STREAM_LAST_EN
      , .out_last(out_last)
`endif
   );

   always #5 clk = ~clk;

   // RAM read port: one-cycle registered read, enable tied high.
   always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Runs one command from a negedge. mode 0: ready always high;
   // mode 1: ready pattern 1,0,0 repeating; mode 2: random ready.
   // abort_at > 0 aborts right after that many beats. With poke_start set,
   // a second start is pulsed while busy and must be ignored.
   task automatic run_cmd(input logic [AW-1:0] a, input logic [AW:0] n,
                          input int mode, input int abort_at, input bit poke_start);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] e, prev_data;
      bit            prev_stall, xfer;
      int            beats, cyc;
      for (int k = 0; k < int'(n); k++) exp_q.push_back(mem[(int'(a) + k) % DEPTH]);
      start = 1'b1; start_addr = a; len = n;
      @(negedge clk);
      start = 1'b0; start_addr = AW'($urandom); len = (AW+1)'($urandom);
      cyc = 1;
      check("busy_after_start", busy, 1);
      check("rd_addr_first", ram_rd_addr, a);
      check("valid_cycle1", out_valid, 0);
      beats = 0; prev_stall = 0; prev_data = '0;
      forever begin
         if (cyc > 4 * int'(n) + 50) begin
            check("timeout", 0, 1);
            out_ready = 1'b0;
            return;
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc - 2) % 3) == 0;
            default: out_ready = ($urandom % 4) != 0;
         endcase
         start = (poke_start && cyc == 3);
         if (start) begin start_addr = 9'h055; len = 10'd3; end
         check("no_early_done", done, 0);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
         end
`ifdef RAM_RD_STREAM_LAST_EN
         if (out_valid) check("last", out_last, exp_q.size() == 1);
`endif
         xfer = out_valid && out_ready;
         if (xfer) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
               e = '0;
            end else begin
               e = exp_q.pop_front();
            end
            check("data", out_data, e);
            if (mode == 0) check("beat_cycle", cyc, beats + 2);
            beats++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (xfer && abort_at != 0 && beats == abort_at) begin
            abort = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_no_done", done, 0);
            repeat (3) begin
               @(negedge clk);
               check("post_abort_done", done, 0);
               check("post_abort_valid", out_valid, 0);
            end
            return;
         end
         if (xfer && exp_q.size() == 0) begin
            check("done_pulse", done, 1);
            check("busy_clear", busy, 0);
            check("valid_clear", out_valid, 0);
            if (mode == 0) check("done_cycle", cyc, int'(n) + 2);
            out_ready = 1'b0;
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_valid", out_valid, 0);
            return;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_addr", ram_rd_addr, 0);
`ifdef RAM_RD_STREAM_LAST_EN
      check("rst_last", out_last, 0);
`endif
      reset_l = 1'b1;
      @(negedge clk);

      run_cmd(9'h010, 10'd4, 0, 0, 0);
      run_cmd(9'h1FE, 10'd4, 0, 0, 0);
      run_cmd(9'h0A0, 10'd8, 1, 0, 1);

      // Zero-length command: done next cycle, never busy, no beats.
      start = 1'b1; start_addr = 9'h030; len = '0;
      @(negedge clk);
      start = 1'b0;
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      check("len0_valid", out_valid, 0);
      @(negedge clk);
      check("len0_done_clear", done, 0);
      check("len0_valid2", out_valid, 0);

      // Abort while idle does nothing.
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_done", done, 0);

      run_cmd(9'h040, 10'd6, 0, 2, 0);
      run_cmd(9'h020, 10'd2, 0, 0, 0);

      // Reset in the middle of a long command.
      start = 1'b1; start_addr = 9'h100; len = 10'd16; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset_l = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_addr", ram_rd_addr, 0);
      check("mid_rst_done", done, 0);
      @(negedge clk);
      reset_l = 1'b1;
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      out_ready = 1'b0;
      run_cmd(AW'($urandom), 10'd1, 0, 0, 0);

      // Random contents, lengths, backpressure and aborts.
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      for (int t = 0; t < 25; t++) begin
         int n, ab;
         n  = $urandom_range(1, 24);
         ab = (($urandom % 5) == 0 && n > 2) ? $urandom_range(1, n - 1) : 0;
         run_cmd(AW'($urandom), (AW+1)'(n), 2, ab, 0);
      end
      run_cmd(AW'($urandom), (AW+1)'(DEPTH), 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
